sram_1rw_arbiter: RTL and testbench
===================================

# sram_1rw_arbiter

Two-requester arbiter and sequencer in front of one 64×16384 single-port (1RW) SRAM macro. It shares the macro's single port between two clients using round-robin valid/ready arbitration and drives the macro's chip-enable, write-enable, address, data and bit-mask pins. It returns read data to the owning client with fixed latency and can optionally zero-initialise the array after reset. It sits between the cache/datapath clients and the hard macro in the memory subsystem.

## Interface
- BITS, 64: data and mask width.
- WORD_DEPTH, 16384: words in the macro.
- ADDR_WIDTH, 14: address width; must equal log2(WORD_DEPTH).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rN_valid  in  1  request from client N (N = 0, 1).
- rN_ready  out  1  client N's request is accepted this cycle.
- rN_we  in  1  1 = write, 0 = read.
- rN_addr  in  ADDR_WIDTH  word address.
- rN_wdata  in  BITS  write data.
- rN_wmask  in  BITS  per-bit write enable; 1 = write the bit.
- rN_rsp_valid  out  1  read data for client N is valid.
- rN_rsp_data  out  BITS  read data.
- init_done  out  1  array is ready to accept client requests.
- sram_ce  out  1  macro chip enable.
- sram_we  out  1  macro write enable.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_wd  out  BITS  macro write data.
- sram_wmask  out  BITS  macro write mask.
- sram_rd  in  BITS  macro registered read data, valid one cycle after a ce cycle.

## Operation
- States: RESET, INIT (only when the macro below is defined), RUN.
  - RESET → INIT or RUN on the first cycle with rst low.
  - INIT → RUN after the last init write.
  - Any state → RESET while rst is high.
- Arbitration (RUN only):
  - The grant is combinational from rN_valid and a 1-bit priority pointer.
  - If only one client is valid, that client is granted.
  - If both are valid, the client selected by the pointer is granted.
  - On every grant, the pointer moves to the other client. If there is no grant, the pointer holds.
- rN_ready equals grantN. A transfer is the cycle where rN_valid and rN_ready are both 1.
- Client request fields must stay stable while valid is high and ready is low.
- sram_ce = grant0 | grant1. sram_we, sram_addr, sram_wd and sram_wmask are muxed from the granted client.
- When sram_ce is 0, sram_we, sram_wd and sram_wmask are driven to 0. sram_addr holds its last value.
- Reads:
  - Registered rsp_owner and rsp_pending are set for every granted read.
  - In the next cycle, r<owner>_rsp_valid = 1 and rN_rsp_data = sram_rd, a combinational pass-through.
  - Both rsp_data outputs carry sram_rd; only the owner's rsp_valid is 1.
- Writes return no response.
- Back-to-back:
  - A new request may be granted in the same cycle as the previous read's response. Full throughput is one access per cycle.
  - A read issued to an address in the cycle after a write to that address returns the new data.
  - There is no same-cycle read/write collision, because the macro has one port.
- Reset:
  - While rst is high, all outputs are 0: ready, rsp_valid, sram_ce, sram_we, sram_wd, sram_wmask and init_done. sram_addr is also 0.
  - The pointer resets to client 0.
  - A read in flight when rst asserts is dropped; no rsp_valid follows.

## Timing
- Request to sram_ce: 0 cycles (combinational).
- Read grant to rsp_valid: exactly 1 cycle.
- init_done:
  - With init: rises on the cycle after the final init write.
  - Without init: high from the first cycle rst is low.
- Worst-case wait for a continuously valid client: 1 cycle.

## Configuration
- SRAM_ARB_INIT_EN defined:
  - After reset, the INIT state runs a 14-bit counter from 0 to WORD_DEPTH−1.
  - Each cycle it drives sram_ce=1, sram_we=1, sram_wd=0, sram_wmask=all ones, sram_addr=counter. This takes WORD_DEPTH cycles.
  - rN_ready is held 0 and init_done=0 during INIT.
  - Reset during INIT restarts the sweep at address 0.
- SRAM_ARB_INIT_EN undefined:
  - No INIT state and no counter; the array contents are undefined after power-up.

## Structure
- Package sram_arb_pkg holds:
  - the ADDR_WIDTH, BITS and WORD_DEPTH defaults;
  - the state enum (ARB_RESET, ARB_INIT, ARB_RUN);
  - the request struct (we, addr, wdata, wmask).
- Sub-module sram_arb_rr2: a 2-way round-robin grant and pointer register, with ports clk, rst, valid[1:0], grant[1:0].

## Test plan
- Single client reads: r0 writes addr 0x0005, data 0xDEAD_BEEF_0000_1111, full mask; r0 then reads 0x0005 → r0_rsp_valid next cycle, data 0xDEAD_BEEF_0000_1111, r1_rsp_valid stays 0.
- Mask merge: write 0xFFFF… to addr 0x3FFF, then write 0 with mask 0x0000_0000_FFFF_FFFF; read → 0xFFFF_FFFF_0000_0000.
- Contention: both clients hold valid reads for 6 cycles → grants alternate r0, r1, r0, …; each rsp_valid follows its own grant by one cycle.
- Write-then-read back-to-back: r1 writes addr 0x1234 = 0x77, r0 reads 0x1234 the next cycle → r0 receives 0x77.
- Reset mid-read: grant an r0 read, assert rst the following cycle → r0_rsp_valid=0, sram_ce=0, pointer back to client 0.
- With SRAM_ARB_INIT_EN: release reset → init_done rises after 16384 cycles and rN_ready stays 0 until then; a read of addr 0x2A00 then returns 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths, arbiter state encoding and client request record
// Contents: BITS/WORD_DEPTH/ADDR_WIDTH defaults, arb_state_e, req_t {we, addr, wdata, wmask}
package sram_arb_pkg;
  localparam int BITS = 64;
  localparam int WORD_DEPTH = 16384;
  localparam int ADDR_WIDTH = 14;
  typedef enum logic [1:0] {ARB_RESET, ARB_INIT, ARB_RUN} arb_state_e;
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BITS-1:0]       wdata;
    logic [BITS-1:0]       wmask;
  } req_t;
endpackage

// File: rtl/sram_arb_rr2.sv
// sram_arb_rr2: two-way round-robin grant with a one-bit priority pointer
// Ports: clk, rst (sync, active high), valid[1:0] requests in, grant[1:0] one-hot grant out
module sram_arb_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic ptr_q, ptr_d;
  always_comb begin
    grant = (valid == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : valid;
    ptr_d = |grant ? grant[0] : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: shares one 1RW SRAM macro between two valid/ready clients with round-robin arbitration
// Ports: clk, rst (sync, active high); per client rN_valid/ready/we/addr/wdata/wmask and rN_rsp_valid/rsp_data;
//        init_done; macro pins sram_ce/we/addr/wd/wmask out, sram_rd (registered read data) in.
// Build option: define SRAM_ARB_INIT_EN to zero-fill the whole array after every reset.
module sram_1rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int BITS       = sram_arb_pkg::BITS,
  parameter int WORD_DEPTH = sram_arb_pkg::WORD_DEPTH,
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [BITS-1:0]       r0_wdata,
  input  logic [BITS-1:0]       r0_wmask,
  output logic                  r0_rsp_valid,
  output logic [BITS-1:0]       r0_rsp_data,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [BITS-1:0]       r1_wdata,
  input  logic [BITS-1:0]       r1_wmask,
  output logic                  r1_rsp_valid,
  output logic [BITS-1:0]       r1_rsp_data,
  output logic                  init_done,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd
);
  arb_state_e state_q, state_d;
  req_t req0, req1, g;
  logic [1:0] valid, grant;
  logic active, ce;
  logic rsp_pending_q, rsp_pending_d, rsp_owner_q, rsp_owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef SRAM_ARB_INIT_EN
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic init_busy;
`endif
  sram_arb_rr2 u_rr2 (.clk(clk), .rst(rst), .valid(valid), .grant(grant));
  always_comb begin
`ifdef SRAM_ARB_INIT_EN
    state_d = state_q == ARB_RESET ? ARB_INIT :
              (state_q == ARB_INIT && cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) ? ARB_RUN : state_q;
    cnt_d = state_q == ARB_INIT ? cnt_q + 1'b1 : '0;
    init_busy = !rst && state_q == ARB_INIT;
    active = !rst && state_q == ARB_RUN;
`else
    // Without the sweep the array is usable from the first cycle out of reset.
    state_d = ARB_RUN;
    active = !rst && state_q != ARB_INIT;
`endif
    req0 = {r0_we, r0_addr, r0_wdata, r0_wmask};
    req1 = {r1_we, r1_addr, r1_wdata, r1_wmask};
    valid = active ? {r1_valid, r0_valid} : 2'b00;
    g = grant[1] ? req1 : req0;
    ce = |grant;
    sram_ce = ce;
    sram_we = ce & g.we;
    sram_wd = ce ? g.wdata : '0;
    sram_wmask = ce ? g.wmask : '0;
    sram_addr = rst ? '0 : ce ? g.addr : addr_q;
`ifdef SRAM_ARB_INIT_EN
    if (init_busy) begin
      sram_ce = 1'b1;
      sram_we = 1'b1;
      sram_wd = '0;
      sram_wmask = '1;
      sram_addr = cnt_q;
    end
`endif
    addr_d = sram_addr;
    rsp_pending_d = ce & ~g.we;
    rsp_owner_d = grant[1];
    r0_ready = grant[0];
    r1_ready = grant[1];
    r0_rsp_valid = !rst && rsp_pending_q && !rsp_owner_q;
    r1_rsp_valid = !rst && rsp_pending_q && rsp_owner_q;
    r0_rsp_data = sram_rd;
    r1_rsp_data = sram_rd;
    init_done = active;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_RESET;
      addr_q <= '0;
      rsp_pending_q <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end
`ifdef SRAM_ARB_INIT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter: vector table, directed sequences and random traffic against a behavioural model
module tb_sram_1rw_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0_valid = 0, r0_we = 0, r1_valid = 0, r1_we = 0;
  logic [13:0] r0_addr = 0, r1_addr = 0;
  logic [63:0] r0_wdata = 0, r0_wmask = 0, r1_wdata = 0, r1_wmask = 0;
  logic r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, init_done;
  logic [63:0] r0_rsp_data, r1_rsp_data;
  logic sram_ce, sram_we;
  logic [13:0] sram_addr;
  logic [63:0] sram_wd, sram_wmask, sram_rd;
  logic [63:0] mem [16384];

  sram_1rw_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_wmask(r0_wmask), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_wmask(r1_wmask), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
    .init_done(init_done), .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wd(sram_wd), .sram_wmask(sram_wmask), .sram_rd(sram_rd)
  );

  always #5 clk = ~clk;

  // Single-port macro with registered read data.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
      else sram_rd <= mem[sram_addr];
    end
  end

  // Reference model state: expected contents, priority client, pending response, last address.
  logic [63:0] gm [int];
  int m_ptr = 0;
  bit m_pend = 0;
  int m_owner = 0;
  logic [63:0] m_data = 0;
  logic [13:0] m_addr = 0;
  bit last_g0 = 0, last_g1 = 0;
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit g0, g1, we;
    logic [13:0] a;
    logic [63:0] wd, wm;
    @(negedge clk);
    g0 = 0;
    g1 = 0;
    if (rst) begin
      chk("rst_ready", {r1_ready, r0_ready}, 0);
      chk("rst_rsp_valid", {r1_rsp_valid, r0_rsp_valid}, 0);
      chk("rst_ce_we", {sram_ce, sram_we}, 0);
      chk("rst_wd", sram_wd, 0);
      chk("rst_wmask", sram_wmask, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_init_done", init_done, 0);
      m_ptr = 0;
      m_pend = 0;
      m_addr = 0;
    end else begin
      g0 = r0_valid && (!r1_valid || m_ptr == 0);
      g1 = r1_valid && !g0;
      chk("r0_ready", r0_ready, g0);
      chk("r1_ready", r1_ready, g1);
      chk("sram_ce", sram_ce, g0 | g1);
      chk("init_done", init_done, 1);
      chk("r0_rsp_valid", r0_rsp_valid, m_pend && m_owner == 0);
      chk("r1_rsp_valid", r1_rsp_valid, m_pend && m_owner == 1);
      if (m_pend) chk("rsp_data", m_owner == 0 ? r0_rsp_data : r1_rsp_data, m_data);
      m_pend = 0;
      if (g0 || g1) begin
        we = g0 ? r0_we : r1_we;
        a = g0 ? r0_addr : r1_addr;
        wd = g0 ? r0_wdata : r1_wdata;
        wm = g0 ? r0_wmask : r1_wmask;
        chk("sram_we", sram_we, we);
        chk("sram_addr", sram_addr, a);
        chk("sram_wd", sram_wd, wd);
        chk("sram_wmask", sram_wmask, wm);
        m_ptr = g0 ? 1 : 0;
        m_addr = a;
        if (we) gm[a] = ((gm.exists(a) ? gm[a] : 64'h0) & ~wm) | (wd & wm);
        else begin
          m_pend = 1;
          m_owner = g1 ? 1 : 0;
          m_data = gm[a];
        end
      end else begin
        chk("idle_we", sram_we, 0);
        chk("idle_wd", sram_wd, 0);
        chk("idle_wmask", sram_wmask, 0);
        chk("idle_addr_hold", sram_addr, m_addr);
      end
    end
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int n;
    rst = 1;
    r0_valid = 1; r0_we = 0;
    r1_valid = 1; r1_we = 0;
    cycle();
    rst = 0;
`ifdef SRAM_ARB_INIT_EN
    n = 0;
    while (!init_done && n < 20000) begin
      chk("init_ready", {r1_ready, r0_ready}, 0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_done_rise", init_done, 1);
    m_addr = 14'h3FFF;
    for (int i = 0; i < 16; i++) gm[i] = 0;
    gm[14'h2A00] = 0;
`else
    n = 0;
`endif
  endtask

  task automatic req(input int c, input bit v, input bit w, input logic [13:0] a,
                     input logic [63:0] d, input logic [63:0] m);
    if (c == 0) begin r0_valid = v; r0_we = w; r0_addr = a; r0_wdata = d; r0_wmask = m; end
    else begin r1_valid = v; r1_we = w; r1_addr = a; r1_wdata = d; r1_wmask = m; end
  endtask

  typedef struct {bit v0; bit v1; bit e0; bit e1;} vec_t;
  vec_t vecs [9];

  initial begin
    vecs = '{'{1,1,1,0}, '{1,1,0,1}, '{1,0,1,0}, '{0,0,0,0}, '{1,1,0,1},
             '{0,1,0,1}, '{1,1,1,0}, '{1,0,1,0}, '{1,1,0,1}};
    do_reset();
    // Clear the random-traffic region through the arbiter.
    for (int i = 0; i < 16; i++) begin
      req(0, 1, 1, 14'(i), 64'h0, '1);
      req(1, 0, 0, 0, 0, 0);
      cycle();
    end
`ifdef SRAM_ARB_INIT_EN
    req(0, 1, 0, 14'h2A00, 0, 0);
    cycle();
    req(0, 0, 0, 0, 0, 0);
    chk("init_zero_data", r0_rsp_data, 0);
    cycle();
`endif
    // Single client write then read.
    req(0, 1, 1, 14'h0005, 64'hDEAD_BEEF_0000_1111, '1);
    cycle();
    req(0, 1, 0, 14'h0005, 0, 0);
    cycle();
    req(0, 0, 0, 0, 0, 0);
    chk("t1_r0_rsp_valid", r0_rsp_valid, 1);
    chk("t1_r1_rsp_valid", r1_rsp_valid, 0);
    chk("t1_data", r0_rsp_data, 64'hDEAD_BEEF_0000_1111);
    cycle();
    // Mask merge.
    req(0, 1, 1, 14'h3FFF, '1, '1);
    cycle();
    req(0, 1, 1, 14'h3FFF, 64'h0, 64'h0000_0000_FFFF_FFFF);
    cycle();
    req(0, 1, 0, 14'h3FFF, 0, 0);
    cycle();
    req(0, 0, 0, 0, 0, 0);
    chk("mask_merge", r0_rsp_data, 64'hFFFF_FFFF_0000_0000);
    cycle();
    // Write by r1 followed immediately by a read of the same address by r0.
    req(1, 1, 1, 14'h1234, 64'h77, '1);
    cycle();
    req(1, 0, 0, 0, 0, 0);
    req(0, 1, 0, 14'h1234, 0, 0);
    cycle();
    req(0, 0, 0, 0, 0, 0);
    chk("raw_data", r0_rsp_data, 64'h77);
    chk("raw_owner", {r1_rsp_valid, r0_rsp_valid}, 2'b01);
    cycle();
    // Arbitration table from a freshly reset pointer.
    do_reset();
    foreach (vecs[i]) begin
      req(0, vecs[i].v0, 0, 14'(i), 0, 0);
      req(1, vecs[i].v1, 0, 14'(i + 1), 0, 0);
      cycle();
      chk($sformatf("vec%0d_grant", i), {last_g1, last_g0}, {vecs[i].e1, vecs[i].e0});
    end
    // Contention: six cycles of reads from both clients alternate grants.
    for (int i = 0; i < 6; i++) begin
      req(0, 1, 0, 14'(i), 0, 0);
      req(1, 1, 0, 14'(i + 8), 0, 0);
      cycle();
    end
    // Random traffic; each client holds its request until accepted.
    req(0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!r0_valid || last_g0)
        req(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom});
      if (!r1_valid || last_g1)
        req(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom});
      cycle();
    end
    // Reset while an r0 read is in flight: response dropped, pointer back to r0.
    req(1, 0, 0, 0, 0, 0);
    req(0, 1, 0, 14'h0005, 0, 0);
    cycle();
    rst = 1;
    cycle();
    chk("rst_drop_rsp", r0_rsp_valid, 0);
    rst = 0;
`ifdef SRAM_ARB_INIT_EN
    do_reset();
`endif
    req(0, 1, 0, 14'h0003, 0, 0);
    req(1, 1, 0, 14'h0004, 0, 0);
    cycle();
    chk("rst_ptr_r0", {last_g1, last_g0}, 2'b01);
    req(0, 0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0, 0);
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
